// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : RV32IM decode constants, FSM encoding and opcode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam logic [6:0] R_TYPE     = 7'b0110011;
    localparam logic [6:0] I_TYPE     = 7'b0010011;
    localparam logic [6:0] LOAD       = 7'b0000011;
    localparam logic [6:0] STORE      = 7'b0100011;
    localparam logic [6:0] JALR       = 7'b1100111;
    localparam logic [6:0] JAL        = 7'b1101111;
    localparam logic [6:0] BRANCH     = 7'b1100011;
    localparam logic [6:0] LUI        = 7'b0110111;
    localparam logic [6:0] AUIPC      = 7'b0010111;
    localparam logic [6:0] ENCRYPTION = 7'b0001011;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_BUBBLE = 2'd2
    } state_e;

    function automatic logic opcode_known(input logic [6:0] op);
        return op inside {R_TYPE, I_TYPE, LOAD, STORE, JALR, JAL,
                          BRANCH, LUI, AUIPC, ENCRYPTION};
    endfunction

    // LUI/AUIPC/JAL carry no rs1 field; every other encoding reads it.
    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op inside {LUI, AUIPC, JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {R_TYPE, STORE, BRANCH, ENCRYPTION};
    endfunction

endpackage : decode_pkg

`default_nettype wire

// File: rtl/decode_stage_if.sv
// ============================================================================
// Module      : decode_stage_if
// Description : Fetch-side and execute-side handshake bundle of decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_stage_if #(
    parameter int ADDRESS_BITS = 16,
    parameter int XLEN         = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDRESS_BITS-1:0] in_pc;
    logic [XLEN-1:0]         in_instr;
    logic                    flush;
    logic                    out_ready;
    logic                    out_valid;
    logic [ADDRESS_BITS-1:0] out_pc;
    logic [6:0]              out_op;
    logic [2:0]              out_funct3;
    logic [6:0]              out_funct7;
    logic [4:0]              out_rs1;
    logic [4:0]              out_rs2;
    logic [4:0]              out_rd;
    logic                    out_wen;
    logic [XLEN-1:0]         out_imm32;
    logic [ADDRESS_BITS-1:0] out_target;
    logic                    out_is_load;
    logic                    out_is_muldiv;
    logic                    out_illegal;
    logic                    hazard_stall;

    // The decode stage itself.
    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_wen, out_imm32, out_target,
               out_is_load, out_is_muldiv, out_illegal, hazard_stall
    );

    // Surrounding fetch/execute logic.
    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_wen, out_imm32, out_target,
               out_is_load, out_is_muldiv, out_illegal, hazard_stall
    );

endinterface : decode_stage_if

`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32 immediate former (I/S/B/U/J/shamt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] instr_i,
    output logic      [XLEN-1:0] imm32_o
);

    logic [6:0] w_op;
    logic [2:0] w_funct3;
    logic       w_sign;

    assign w_op     = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_sign   = instr_i[31];

    always_comb begin
        imm32_o = '0;
        case (w_op)
            LOAD, JALR: imm32_o = {{(XLEN-12){w_sign}}, instr_i[31:20]};
            I_TYPE: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                    imm32_o = {{(XLEN-5){1'b0}}, instr_i[24:20]};
                else
                    imm32_o = {{(XLEN-12){w_sign}}, instr_i[31:20]};
            end
            STORE:  imm32_o = {{(XLEN-12){w_sign}}, instr_i[31:25], instr_i[11:7]};
            BRANCH: imm32_o = {{(XLEN-12){w_sign}}, instr_i[7], instr_i[30:25],
                               instr_i[11:8], 1'b0};
            LUI, AUIPC: imm32_o = {{(XLEN-31){w_sign}}, instr_i[30:12], 12'b0};
            JAL:    imm32_o = {{(XLEN-20){w_sign}}, instr_i[19:12], instr_i[20],
                               instr_i[30:21], 1'b0};
            default: imm32_o = '0;
        endcase
    end

endmodule : imm_gen

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32IM decode stage with load-use bubble and flush.
//               Optional macro DECODE_MEXT_EN enables M-extension decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter int ADDRESS_BITS = 16,
    parameter int XLEN         = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    decode_stage_if.slave  bus
);

    logic [6:0]              w_op;
    logic [2:0]              w_funct3;
    logic [6:0]              w_funct7;
    logic [4:0]              w_rs1;
    logic [4:0]              w_rs2;
    logic [4:0]              w_rd;
    logic [XLEN-1:0]         w_imm;
    logic [ADDRESS_BITS-1:0] w_target;
    logic                    w_is_mul_enc;
    logic                    w_is_muldiv;
    logic                    w_illegal;
    logic                    w_wen;
    logic                    w_hazard;
    logic                    w_in_ready;
    logic                    w_accept;

    state_e                  state_q;
    logic                    valid_q;
    logic [ADDRESS_BITS-1:0] pc_q;
    logic [6:0]              op_q;
    logic [2:0]              funct3_q;
    logic [6:0]              funct7_q;
    logic [4:0]              rs1_q;
    logic [4:0]              rs2_q;
    logic [4:0]              rd_q;
    logic                    wen_q;
    logic [XLEN-1:0]         imm_q;
    logic [ADDRESS_BITS-1:0] target_q;
    logic                    is_load_q;
    logic                    is_muldiv_q;
    logic                    illegal_q;

    assign w_op     = bus.in_instr[6:0];
    assign w_rd     = bus.in_instr[11:7];
    assign w_funct3 = bus.in_instr[14:12];
    assign w_rs1    = bus.in_instr[19:15];
    assign w_rs2    = bus.in_instr[24:20];
    assign w_funct7 = bus.in_instr[31:25];

    imm_gen #(
        .XLEN    (XLEN)
    ) u_imm_gen (
        .instr_i (bus.in_instr),
        .imm32_o (w_imm)
    );

    // Wraps modulo 2^ADDRESS_BITS; only meaningful for BRANCH/JAL/AUIPC.
    assign w_target = bus.in_pc + w_imm[ADDRESS_BITS-1:0];

    assign w_is_mul_enc = (w_op == R_TYPE) && (w_funct7 == MULDIV_FUNCT7);

`ifdef DECODE_MEXT_EN
    assign w_is_muldiv = w_is_mul_enc;
    assign w_illegal   = !opcode_known(w_op);
`else
    assign w_is_muldiv = 1'b0;
    assign w_illegal   = !opcode_known(w_op) || w_is_mul_enc;
`endif

    assign w_wen = !(w_illegal || (w_op == STORE) || (w_op == BRANCH) ||
                     (w_op == ENCRYPTION) || (w_rd == 5'd0));

    assign w_hazard = valid_q && is_load_q && (rd_q != 5'd0) && bus.in_valid &&
                      ((uses_rs1(w_op) && (w_rs1 == rd_q)) ||
                       (uses_rs2(w_op) && (w_rs2 == rd_q)));

    // Flush always consumes the incoming word so fetch can redirect at once.
    assign w_in_ready = bus.flush || ((!valid_q || bus.out_ready) && !w_hazard);
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            valid_q     <= 1'b0;
            pc_q        <= '0;
            op_q        <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            imm_q       <= '0;
            target_q    <= '0;
            is_load_q   <= 1'b0;
            is_muldiv_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (bus.flush) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
        end else if (w_accept) begin
            state_q     <= ST_FULL;
            valid_q     <= 1'b1;
            pc_q        <= bus.in_pc;
            op_q        <= w_op;
            funct3_q    <= w_funct3;
            funct7_q    <= w_funct7;
            rs1_q       <= w_rs1;
            rs2_q       <= w_rs2;
            rd_q        <= w_rd;
            wen_q       <= w_wen;
            imm_q       <= w_imm;
            target_q    <= w_target;
            is_load_q   <= (w_op == LOAD);
            is_muldiv_q <= w_is_muldiv;
            illegal_q   <= w_illegal;
        end else if (w_hazard && bus.out_ready) begin
            state_q <= ST_BUBBLE;
            valid_q <= 1'b0;
        end else if (valid_q && bus.out_ready) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
        end else if (state_q == ST_BUBBLE) begin
            state_q <= ST_EMPTY;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.hazard_stall  = w_hazard && bus.out_ready && !bus.flush;
    assign bus.out_valid     = valid_q;
    assign bus.out_pc        = pc_q;
    assign bus.out_op        = op_q;
    assign bus.out_funct3    = funct3_q;
    assign bus.out_funct7    = funct7_q;
    assign bus.out_rs1       = rs1_q;
    assign bus.out_rs2       = rs2_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_wen       = wen_q;
    assign bus.out_imm32     = imm_q;
    assign bus.out_target    = target_q;
    assign bus.out_is_load   = is_load_q;
    assign bus.out_is_muldiv = is_muldiv_q;
    assign bus.out_illegal   = illegal_q;

endmodule : decode_stage

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed and randomized self-checking bench for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] imm;
        logic [15:0] target;
        logic        is_load;
        logic        is_muldiv;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.ADDRESS_BITS(16), .XLEN(32)) bus ();

    decode_stage #(
        .ADDRESS_BITS (16),
        .XLEN         (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t act;
    assign act = {bus.out_op, bus.out_funct3, bus.out_funct7, bus.out_rs1,
                  bus.out_rs2, bus.out_rd, bus.out_wen, bus.out_imm32,
                  bus.out_target, bus.out_is_load, bus.out_is_muldiv,
                  bus.out_illegal};

    function automatic int sx(input int val, input int bits);
        if (val >= (1 << (bits - 1))) return val - (1 << bits);
        return val;
    endfunction

    function automatic exp_t ref_decode(input logic [15:0] pc, input logic [31:0] ins);
        exp_t e;
        int   immv;
        logic known;
        logic mul;
        logic [6:0] op;
        op  = ins[6:0];
        e   = '0;
        e.op = op; e.f3 = ins[14:12]; e.f7 = ins[31:25];
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        known = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h6F,
                           7'h63, 7'h37, 7'h17, 7'h0B};
        mul = (op == 7'h33) && (ins[31:25] == 7'h01);
`ifdef DECODE_MEXT_EN
        e.is_muldiv = mul;
        e.illegal   = !known;
`else
        e.is_muldiv = 1'b0;
        e.illegal   = !known || mul;
`endif
        e.is_load = (op == 7'h03);
        e.wen = !(e.illegal || op == 7'h23 || op == 7'h63 || op == 7'h0B || e.rd == 5'd0);
        case (op)
            7'h03, 7'h67: immv = sx(int'(ins[31:20]), 12);
            7'h13: immv = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ?
                          int'(ins[24:20]) : sx(int'(ins[31:20]), 12);
            7'h23: immv = sx(int'({ins[31:25], ins[11:7]}), 12);
            7'h63: immv = sx(int'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
            7'h37, 7'h17: immv = int'(ins & 32'hFFFF_F000);
            7'h6F: immv = sx(int'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
            default: immv = 0;
        endcase
        e.imm    = immv;
        e.target = 16'((int'(pc) + immv) & 32'h0000_FFFF);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [0:11];
        logic [6:0]  op;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h6F,
                7'h63, 7'h37, 7'h17, 7'h0B, 7'h7F, 7'h03};
        ins = $urandom;
        op  = ops[$urandom_range(0, 11)];
        ins[6:0]   = op;
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        if (op == 7'h33) begin
            case ($urandom_range(0, 2))
                0:       ins[31:25] = 7'h00;
                1:       ins[31:25] = 7'h20;
                default: ins[31:25] = 7'h01;
            endcase
        end
        return ins;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: out_valid=%b hazard_stall=%b, required 0/0",
                     bus.out_valid, bus.hazard_stall);
        end
        checks++;
        if (act !== '0 || bus.out_pc !== 16'h0) begin
            errors++;
            $display("FAIL reset_fields: fields=%h pc=%h, required all zero", act, bus.out_pc);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        bus.out_ready = 1'b1; bus.flush = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc = 16'h0040; bus.in_instr = 32'h0000A283;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL lu_accept_lw: in_ready=%b, required 1", bus.in_ready);
        end
        tick();
        bus.in_pc = 16'h0044; bus.in_instr = 32'h00228333;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_is_load !== 1'b1 || bus.out_rd !== 5'd5 ||
            bus.hazard_stall !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL lu_hazard: valid=%b load=%b rd=%0d stall=%b in_ready=%b, required 1/1/5/1/0",
                     bus.out_valid, bus.out_is_load, bus.out_rd, bus.hazard_stall, bus.in_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.hazard_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_bubble: valid=%b stall=%b in_ready=%b, required 0/0/1",
                     bus.out_valid, bus.hazard_stall, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0044 || bus.out_rs1 !== 5'd5 ||
            bus.out_rs2 !== 5'd2 || bus.out_rd !== 5'd6 || bus.out_wen !== 1'b1) begin
            errors++;
            $display("FAIL lu_add: valid=%b pc=%h rs1=%0d rs2=%0d rd=%0d wen=%b, required 1/0044/5/2/6/1",
                     bus.out_valid, bus.out_pc, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_wen);
        end
        tick();
    endtask

    task automatic test_branch_target();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.in_pc = 16'h0010; bus.in_instr = 32'hFE000EE3;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm32 !== 32'hFFFF_FFFC ||
            bus.out_target !== 16'h000C || bus.out_wen !== 1'b0) begin
            errors++;
            $display("FAIL branch_target: valid=%b imm=%h target=%h wen=%b, required 1/fffffffc/000c/0",
                     bus.out_valid, bus.out_imm32, bus.out_target, bus.out_wen);
        end
        tick();
    endtask

    task automatic test_wrap();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.in_pc = 16'hFFFC; bus.in_instr = 32'h008000EF;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_target !== 16'h0004 || bus.out_rd !== 5'd1 ||
            bus.out_wen !== 1'b1 || bus.out_imm32 !== 32'd8) begin
            errors++;
            $display("FAIL jal_wrap: valid=%b target=%h rd=%0d wen=%b imm=%h, required 1/0004/1/1/00000008",
                     bus.out_valid, bus.out_target, bus.out_rd, bus.out_wen, bus.out_imm32);
        end
        tick();
    endtask

    task automatic test_backpressure_flush();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.in_pc = 16'h0100; bus.in_instr = 32'h00500393;
        tick();
        bus.in_pc = 16'h0104; bus.in_instr = 32'h00100413;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_pc !== 16'h0100 ||
                bus.out_rd !== 5'd7 || bus.out_imm32 !== 32'd5 || bus.out_op !== 7'h13) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b in_ready=%b pc=%h rd=%0d imm=%h op=%h, required 1/0/0100/7/00000005/13",
                         k, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_rd, bus.out_imm32, bus.out_op);
            end
            tick();
        end
        bus.flush = 1'b1; bus.in_pc = 16'h0200; bus.in_instr = 32'h00200493;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_ready: in_ready=%b, required 1", bus.in_ready);
        end
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_drop%0d: out_valid=%b pc=%h, required out_valid=0",
                         k, bus.out_valid, bus.out_pc);
            end
            tick();
        end
    endtask

    task automatic test_mext();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.in_pc = 16'h0300; bus.in_instr = 32'h022081B3;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
`ifdef DECODE_MEXT_EN
        if (bus.out_valid !== 1'b1 || bus.out_is_muldiv !== 1'b1 || bus.out_illegal !== 1'b0 ||
            bus.out_wen !== 1'b1 || bus.out_rd !== 5'd3) begin
            errors++;
            $display("FAIL mext_mul: valid=%b muldiv=%b illegal=%b wen=%b rd=%0d, required 1/1/0/1/3",
                     bus.out_valid, bus.out_is_muldiv, bus.out_illegal, bus.out_wen, bus.out_rd);
        end
`else
        if (bus.out_valid !== 1'b1 || bus.out_is_muldiv !== 1'b0 || bus.out_illegal !== 1'b1 ||
            bus.out_wen !== 1'b0 || bus.out_rd !== 5'd3) begin
            errors++;
            $display("FAIL mext_mul: valid=%b muldiv=%b illegal=%b wen=%b rd=%0d, required 1/0/1/0/3",
                     bus.out_valid, bus.out_is_muldiv, bus.out_illegal, bus.out_wen, bus.out_rd);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.in_pc = 16'h0400; bus.in_instr = 32'h00228333;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: out_valid=%b, required 1", bus.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || act !== '0 || bus.out_pc !== 16'h0 ||
            bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b fields=%h pc=%h stall=%b, required all zero",
                     bus.out_valid, act, bus.out_pc, bus.hazard_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic held_v;
        exp_t held;
        exp_t inc;
        logic hz;
        logic exp_rdy;
        logic exp_stall;
        held_v = 1'b0;
        held   = '0;
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.in_pc     = 16'($urandom);
            bus.in_instr  = rand_instr();
            inc = ref_decode(bus.in_pc, bus.in_instr);
            hz = held_v && held.is_load && (held.rd != 5'd0) && bus.in_valid &&
                 (((inc.op != 7'h37 && inc.op != 7'h17 && inc.op != 7'h6F) && inc.rs1 == held.rd) ||
                  ((inc.op inside {7'h33, 7'h23, 7'h63, 7'h0B}) && inc.rs2 == held.rd));
            exp_rdy   = bus.flush || ((!held_v || bus.out_ready) && !hz);
            exp_stall = hz && bus.out_ready && !bus.flush;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== held_v || bus.in_ready !== exp_rdy ||
                bus.hazard_stall !== exp_stall) begin
                errors++;
                $display("FAIL rand_ctrl@%0d: valid=%b in_ready=%b stall=%b, required %b/%b/%b",
                         n, bus.out_valid, bus.in_ready, bus.hazard_stall, held_v, exp_rdy, exp_stall);
            end
            if (held_v) begin
                checks++;
                if (act !== held) begin
                    errors++;
                    $display("FAIL rand_fields@%0d: got=%h required=%h", n, act, held);
                end
            end
            if (bus.flush) held_v = 1'b0;
            else if (bus.in_valid && exp_rdy) begin
                held_v = 1'b1;
                held   = inc;
            end else if (bus.out_ready) held_v = 1'b0;
            tick();
        end
        bus.in_valid = 1'b0; bus.flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_load_use();
        test_branch_target();
        test_wrap();
        test_backpressure_flush();
        test_mext();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_decode_stage

`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32IM decode stage between fetch and execute.
- Decodes fields, forms all immediates (I/S/B/U/J/shamt) and computes the PC-relative target at full ADDRESS_BITS width.
- Holds the result in an output pipeline register with valid/ready handshakes on both sides.
- Inserts exactly one bubble on a load-use hazard; supports synchronous flush from branch resolution.

Parameters:
- ADDRESS_BITS, 16, width of PC and target.
- XLEN, 32, width of instruction and imm32.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  ADDRESS_BITS  PC of in_instr
- in_instr  in  XLEN  raw instruction
- flush  in  1  discard held and incoming instruction
- out_ready  in  1  execute accepts
- out_valid  out  1  output register holds a live instruction
- out_pc  out  ADDRESS_BITS  registered PC
- out_op / out_funct3 / out_funct7  out  7/3/7  decoded fields
- out_rs1 / out_rs2 / out_rd  out  5/5/5  register selects
- out_wen  out  1  GPR write enable
- out_imm32  out  XLEN  selected sign/zero-extended immediate
- out_target  out  ADDRESS_BITS  out_pc + imm32[ADDRESS_BITS-1:0], mod 2^ADDRESS_BITS
- out_is_load  out  1  op==0000011
- out_is_muldiv  out  1  M-extension R-type
- out_illegal  out  1  unrecognised opcode
- hazard_stall  out  1  bubble being inserted this cycle

Behaviour:
- Reset (async): state=EMPTY; every out_* and hazard_stall = 0.
- State machine:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - BUBBLE: out_valid=0; lasts exactly one cycle, then acts as EMPTY.
- Hazard (combinational): out_valid & out_is_load & out_rd!=0 & in_valid & ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)).
  - uses_rs1: false only for LUI, AUIPC, JAL.
  - uses_rs2: R-type, STORE, BRANCH, ENCRYPTION.
- in_ready = flush | ((!out_valid | out_ready) & !hazard).
- Accept (in_valid & in_ready & !flush): output register loads the decoded instruction next edge; state→FULL.
- Drain (out_valid & out_ready, no accept): state→EMPTY.
- Hazard with out_ready=1: load leaves; state→BUBBLE; hazard_stall=1 this cycle. The dependent instruction is accepted the following cycle.
- Hazard with out_ready=0: hold; in_ready=0.
- Flush has priority: next edge state→EMPTY, out_valid=0, incoming instruction consumed and dropped (in_ready=1).
- Latency: one cycle in→out, plus one bubble cycle on a load-use hazard.
- Immediates:
  - I = load / JALR / OP-IMM non-shift.
  - S = store.
  - B = {sext, i[7], i[30:25], i[11:8], 0}.
  - U = {i[31:12], 12'b0} for LUI (0110111) and AUIPC (0010111).
  - J = jal.
  - Shamt zero-extended for SLLI/SRLI/SRAI.
  - 0 for R-type and ENCRYPTION.
- out_target: valid for BRANCH, JAL, AUIPC; the adder wraps silently. JALR target is not computed here.
- out_wen = 0 for STORE, BRANCH, ENCRYPTION (0001011), illegal opcodes, or rd==0; otherwise 1.
- out_illegal = 1 for any opcode outside {R, OP-IMM, LOAD, STORE, JALR, JAL, BRANCH, LUI, AUIPC, ENCRYPTION}. The instruction is still passed with wen=0.
- All outputs hold their values while out_valid & !out_ready.

Optional Feature:
- Macro: DECODE_MEXT_EN.
- Defined: R-type with funct7=0000001 sets out_is_muldiv=1, wen per the rule above.
- Undefined: out_is_muldiv tied 0; funct7=0000001 R-type flagged out_illegal=1, wen=0.

Decomposition:
- Package decode_pkg: opcode constants (R_TYPE, I_TYPE, LOAD, STORE, JALR, JAL, BRANCH, LUI, AUIPC, ENCRYPTION), M funct7 constant, state encoding.
- One combinational sub-module imm_gen: (instruction) → imm32, instantiated once.
- FSM, hazard logic and output register stay in decode_stage.

Test Plan:
- Load-use: accept lw x5,0(x1) (0x0000A283), then add x6,x5,x2 (0x00228333) with out_ready=1.
  - Required: hazard_stall=1 for one cycle, out_valid low for exactly one cycle, add appears with rs1=5, rs2=2, rd=6, wen=1.
- Branch target: pc=0x0010, beq x0,x0,-4 (0xFE000EE3).
  - Required: out_imm32=0xFFFFFFFC, out_target=0x000C, out_wen=0.
- Wrap: pc=0xFFFC, jal x1,8 (0x008000EF).
  - Required: out_target=0x0004, out_rd=1, out_wen=1.
- Backpressure and flush: out_ready=0 for 3 cycles, then flush with in_valid=1.
  - Required: outputs stable for those 3 cycles, in_ready=0; on flush in_ready=1, next cycle out_valid=0, dropped instruction never appears.
- M-extension: mul x3,x1,x2 (0x022081B3).
  - With DECODE_MEXT_EN: out_is_muldiv=1, out_illegal=0.
  - Without: out_illegal=1, out_wen=0.
- Reset mid-operation: assert rst while FULL.
  - Required: out_valid and all out_* = 0 immediately, without waiting for a clock edge.
